mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Sits directly downstream of the load/store buffer and beside instruction fetch.
- Arbitrates between the two clients and serialises their requests onto the byte-wide RAM/IO bus.
- Loads and fetches are assembled little-endian; stores are split into bytes.
- Returns load data to the LSB, which broadcasts it on its result bus.

Parameters:
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are memory-mapped IO (stores subject to io_buffer_full).

Ports:
- clk_in  input  1  clock, all state changes on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; 0 freezes all state.
- clr_in  input  1  misprediction flush.
- io_buffer_full  input  1  IO write buffer full; blocks IO stores.
- mem_din  input  8  RAM read byte; valid one cycle after its address.
- mem_dout  output  8  RAM write byte.
- mem_a  output  32  RAM byte address.
- mem_wr  output  1  1 = write, 0 = read.
- if_req  input  1  fetch request; held until if_done.
- if_addr  input  32  fetch address; 4 bytes read.
- if_done  output  1  one-cycle pulse, if_data valid.
- if_data  output  32  fetched word.
- lsb_req  input  1  LSB request; held until lsb_done.
- lsb_wr  input  1  1 = store, 0 = load.
- lsb_addr  input  32  access address.
- lsb_len  input  2  0 = byte, 1 = half, 2 = word (3 treated as word).
- lsb_sext  input  1  sign-extend byte/half loads.
- lsb_wdata  input  32  store data; low bytes used.
- lsb_done  output  1  one-cycle pulse.
- lsb_rdata  output  32  extended load result, valid with lsb_done.

Behaviour:
- Reset (rst_in = 0, async):
  - state = IDLE.
  - mem_a, mem_dout, mem_wr, if_done, lsb_done, if_data and lsb_rdata all 0.
- rdy_in = 0: no state, counter or output register changes; mem_wr is forced to 0 combinationally.
- States: IDLE, READ, WRITE.
- IDLE:
  - lsb_req has priority over if_req.
  - Latch client, base address, byte count n (1/2/4), wdata and sext; set byte counter k = 0.
  - Go to READ (fetch or load) or WRITE (store).
  - No request: stay in IDLE with mem_wr = 0.
- READ timing:
  - Cycle k (0..n-1) drives mem_a = base+k, mem_wr = 0.
  - Byte k is captured from mem_din in cycle k+1 into bits [8k+7:8k].
  - Done pulse in cycle n+1 after entry (word: 5 cycles IDLE-exit to done).
  - Return to IDLE.
- Load extension:
  - Byte: bit 7 replicated if sext, else zero.
  - Half: bit 15 replicated if sext, else zero.
  - Word: unchanged.
- WRITE timing:
  - Cycle k drives mem_a = base+k, mem_dout = wdata[8k+7:8k], mem_wr = 1.
  - Done pulse in the cycle after the last byte.
  - Return to IDLE.
- IO stall: if base >= IO_BASE and io_buffer_full = 1, the WRITE byte cycle drives mem_wr = 0, does not advance k, and retries next cycle.
- After any done pulse the controller spends exactly one cycle in IDLE before accepting, so a still-high req in the done cycle is never re-serviced.
- Arbitration: an in-flight request is never pre-empted. A request raised mid-transaction waits.
- Address wrap: base+k uses 32-bit modular addition.
- clr_in = 1:
  - IDLE: no new request is accepted that cycle.
  - READ: aborted, no done pulse, next state IDLE.
  - WRITE: continues to completion (stores reaching this block are committed); its lsb_done is still pulsed.
  - clr_in takes effect only when rdy_in = 1.
- Done pulses last exactly one cycle; if_done and lsb_done are never high together.
- Reset mid-transaction: immediate abandon to IDLE, mem_wr = 0 asynchronously.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,00,50,00; if_req, if_addr = 0x100 -> if_done 5 cycles later, if_data = 0x00500013; mem_wr stays 0.
- Signed loads: RAM[0x200] = 0x80, lsb_len = 0, sext = 1 -> lsb_rdata = 0xFFFFFF80. Same with sext = 0 -> 0x00000080. Half at 0x200 with RAM[0x201] = 0xFF, sext = 1 -> 0xFFFFFF80.
- Store word: lsb_wdata = 0xDEADBEEF at 0x400 -> four consecutive mem_wr = 1 cycles with bytes EF, BE, AD, DE at 0x400..0x403; lsb_done the next cycle.
- Arbitration: if_req and lsb_req rise together -> LSB serviced first; one idle cycle; then fetch. No double service while req is held through done.
- IO stall: store byte to 0x30000 with io_buffer_full = 1 for 3 cycles -> mem_wr = 0 for those cycles, then a single write of the byte; lsb_done follows.
- Flush and freeze: clr_in during a fetch READ -> no if_done, back to IDLE. clr_in during a store -> store completes with lsb_done. rdy_in = 0 mid-read -> mem_a and counter hold, resume exactly. rst_in low mid-write -> mem_wr = 0 immediately.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller. It arbitrates the LSB (priority) against
// instruction fetch, assembles loads little-endian and splits stores into bytes.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_len,
  input  logic        lsb_sext,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        lsb_sel_q, lsb_sel_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] wdata_q, wdata_d;
  logic        sext_q, sext_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        if_done_q, if_done_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;

  logic        stall;
  logic [2:0]  k_nx;
  logic [2:0]  cap_idx;
  logic [31:0] asm_w;
  logic [31:0] new_base;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'd0:    len_to_n = 3'd1;
      2'd1:    len_to_n = 3'd2;
      default: len_to_n = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n,
                                         input logic sx);
    case (n)
      3'd1:    extend = {{24{sx & w[7]}}, w[7:0]};
      3'd2:    extend = {{16{sx & w[15]}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  // Only the WRITE byte cycle strobes the bus; an IO store with a full buffer retries.
  assign stall     = (base_q >= IO_BASE) && io_buffer_full;
  assign mem_wr    = (state_q == S_WRITE) && rdy_in && !stall;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign if_done   = if_done_q;
  assign lsb_done  = lsb_done_q;
  assign if_data   = if_data_q;
  assign lsb_rdata = lsb_rdata_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    lsb_sel_d   = lsb_sel_q;
    base_d      = base_q;
    n_d         = n_q;
    k_d         = k_q;
    wdata_d     = wdata_q;
    sext_d      = sext_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    if_done_d   = if_done_q;
    lsb_done_d  = lsb_done_q;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;

    k_nx     = k_q + 3'd1;
    cap_idx  = k_q - 3'd1;
    asm_w    = buf_q;
    asm_w[{cap_idx[1:0], 3'b000} +: 8] = mem_din;
    new_base = lsb_req ? lsb_addr : if_addr;

    if (rdy_in) begin
      if_done_d  = 1'b0;
      lsb_done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          // The cycle holding a done pulse never accepts, so a held req is not re-serviced.
          if (!clr_in && !if_done_q && !lsb_done_q && (lsb_req || if_req)) begin
            lsb_sel_d = lsb_req;
            base_d    = new_base;
            n_d       = lsb_req ? len_to_n(lsb_len) : 3'd4;
            wdata_d   = lsb_wdata;
            sext_d    = lsb_sext;
            k_d       = 3'd0;
            buf_d     = 32'd0;
            mem_a_d   = new_base;
            if (lsb_req && lsb_wr) begin
              state_d    = S_WRITE;
              mem_dout_d = lsb_wdata[7:0];
            end else begin
              state_d = S_READ;
            end
          end
        end
        S_READ: begin
          // k counts bus cycles; the byte addressed in cycle k-1 arrives in cycle k.
          if (clr_in) begin
            state_d = S_IDLE;
          end else begin
            if (k_q != 3'd0) buf_d = asm_w;
            if (k_q == n_q) begin
              state_d = S_IDLE;
              if (lsb_sel_q) begin
                lsb_done_d  = 1'b1;
                lsb_rdata_d = extend(asm_w, n_q, sext_q);
              end else begin
                if_done_d = 1'b1;
                if_data_d = asm_w;
              end
            end else begin
              k_d = k_nx;
              if (k_nx != n_q) mem_a_d = base_q + {29'd0, k_nx};
            end
          end
        end
        S_WRITE: begin
          if (!stall) begin
            if (k_nx == n_q) begin
              state_d    = S_IDLE;
              lsb_done_d = 1'b1;
            end else begin
              k_d        = k_nx;
              mem_a_d    = base_q + {29'd0, k_nx};
              mem_dout_d = wdata_q[{k_nx[1:0], 3'b000} +: 8];
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      lsb_sel_q   <= 1'b0;
      base_q      <= 32'd0;
      n_q         <= 3'd0;
      k_q         <= 3'd0;
      wdata_q     <= 32'd0;
      sext_q      <= 1'b0;
      buf_q       <= 32'd0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= 32'd0;
      lsb_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      lsb_sel_q   <= lsb_sel_d;
      base_q      <= base_d;
      n_q         <= n_d;
      k_q         <= k_d;
      wdata_q     <= wdata_d;
      sext_q      <= sext_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

endmodule
